// File: rtl/inv_sqrt_arbiter_pkg.sv
// Shared constants for the inverse-square-root arbiter: FSM encoding, requester indices and
// default widths/limits.
package inv_sqrt_arbiter_pkg;

  localparam int unsigned ACC_MAG_SQR_WIDTH = 32;
  localparam int unsigned DEFAULT_TIMEOUT   = 64;

  localparam int unsigned REQ_ACC  = 0;
  localparam int unsigned REQ_QUAT = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/inv_sqrt_arbiter_if.sv
// Requester and core handshake buses around the inverse-square-root arbiter.
// Index [0] is the accelerometer requester, [1] the quaternion requester.
interface inv_sqrt_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_data;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                core_valid_in;
  logic                core_ready_in;
  logic [DATA_W-1:0]   core_data_in;
  logic                core_valid_out;
  logic                core_ready_out;
  logic [DATA_W-1:0]   core_data_out;

  // The arbiter itself.
  modport master (
    input  req_valid, req_data, rsp_ready, core_ready_in, core_valid_out, core_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, core_valid_in, core_data_in, core_ready_out
  );

  // The requesters and the core taken together.
  modport slave (
    output req_valid, req_data, rsp_ready, core_ready_in, core_valid_out, core_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, core_valid_in, core_data_in, core_ready_out
  );
endinterface

// File: rtl/inv_sqrt_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; ptr_i names the favoured requester.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o[0] = req_i[0] & (~ptr_i | ~req_i[1]);
    grant_o[1] = req_i[1] & (ptr_i | ~req_i[0]);
  end
endmodule

// File: rtl/inv_sqrt_arbiter.sv
// Shares one multi-cycle inverse-square-root core between acc and quat normalisation.
// Optional watchdog abort on a silent core is enabled by defining INV_SQRT_WDT_EN.
module inv_sqrt_arbiter
  import inv_sqrt_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = ACC_MAG_SQR_WIDTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  inv_sqrt_arbiter_if.master bus
);

  state_e            state_q;
  logic              owner_q;
  logic              rr_ptr_q;
  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] result_q;
  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              drop;

`ifdef INV_SQRT_WDT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            drop_q;
  logic            err_q;

  assign drop = drop_q;
`else
  assign drop = 1'b0;
`endif

  // No new grants while a timed-out result may still arrive from the core.
  assign arb_req = (state_q == StIdle && !drop) ? bus.req_valid : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    bus.req_ready      = grant;
    bus.core_valid_in  = (state_q == StIssue);
    bus.core_data_in   = op_q;
    bus.core_ready_out = (state_q == StWait) | drop;
    bus.rsp_valid      = 2'b00;
    if (state_q == StResp) bus.rsp_valid[owner_q] = 1'b1;
    bus.rsp_data       = result_q;
`ifdef INV_SQRT_WDT_EN
    bus.rsp_err        = err_q;
`else
    bus.rsp_err        = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
`ifdef INV_SQRT_WDT_EN
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef INV_SQRT_WDT_EN
      if (drop_q && bus.core_valid_out) drop_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            op_q    <= grant[REQ_QUAT] ? bus.req_data[REQ_QUAT*DATA_W +: DATA_W]
                                       : bus.req_data[REQ_ACC*DATA_W +: DATA_W];
            owner_q <= grant[REQ_QUAT];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (bus.core_ready_in) begin
            state_q <= StWait;
`ifdef INV_SQRT_WDT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StWait: begin
          if (bus.core_valid_out) begin
            result_q <= bus.core_data_out;
`ifdef INV_SQRT_WDT_EN
            err_q    <= 1'b0;
`endif
            state_q  <= StResp;
          end
`ifdef INV_SQRT_WDT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            drop_q   <= 1'b1;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          if (bus.rsp_ready[owner_q]) begin
            rr_ptr_q <= ~owner_q;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
